// File: rtl/event_builder_rr_timeout.sv
// Trigger-matched event builder: frames header, round-robin TDC words and trailer
// per trigger, with channel mask, event timeout, hit truncation and status counters.
module event_builder_rr_timeout #(
    parameter int TDC_COUNT      = 10,
    parameter int TDC_DATA_WIDTH = 40,
    parameter int TIMEOUT_WIDTH  = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic [TDC_COUNT-1:0]                tdc_enable_mask,
    input  logic [TIMEOUT_WIDTH-1:0]            timeout_cycles,
    input  logic [9:0]                          max_hits,
    input  logic                                trigger_fifo_empty,
    input  logic [28:0]                         trigger_fifo_data,
    output logic                                trigger_fifo_read,
    input  logic [TDC_COUNT-1:0]                locked_array,
    input  logic [TDC_COUNT-1:0]                tdc_fifo_empty_array,
    input  logic [TDC_COUNT*TDC_DATA_WIDTH-1:0] tdc_fifo_data_array,
    output logic [TDC_COUNT-1:0]                tdc_fifo_read_array,
    input  logic                                readout_fifo_full,
    output logic [TDC_DATA_WIDTH-1:0]           event_data,
    output logic                                event_data_ready,
    output logic                                building_busy,
    output logic [15:0]                         event_count,
    output logic [15:0]                         timeout_count
);

    localparam int GW = (TDC_COUNT > 1) ? $clog2(TDC_COUNT) : 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_TRIG  = 3'd1,
        SEND_HEAD  = 3'd2,
        SEND_DATA  = 3'd3,
        SEND_TRAIL = 3'd4
    } state_t;

    state_t state;
    state_t state_nx;

    logic [28:0]              trig_reg;
    logic [TDC_COUNT-1:0]     event_mask;
    logic [TDC_COUNT-1:0]     readable;
    logic [TDC_COUNT-1:0]     header_found;
    logic [TDC_COUNT-1:0]     trailer_found;
    logic [4:0]               header_count;
    logic [4:0]               trailer_count;
    logic [9:0]               hit_count;
    logic [TIMEOUT_WIDTH-1:0] timer;
    logic                     timeout_flag;
    logic                     trunc_flag;
    logic [GW-1:0]            last_grant;

    logic [TDC_COUNT-1:0]      candidates;
    logic                      grant_valid;
    logic [GW-1:0]             grant_idx;
    logic [TDC_COUNT-1:0]      grant_onehot;
    logic [TDC_DATA_WIDTH-1:0] grant_word;
    logic                      is_hdr;
    logic                      is_trl;
    logic                      is_hit;
    logic                      hit_fwd;
    logic                      pop;
    logic                      timeout_hit;
    logic                      word_valid;
    logic [TDC_DATA_WIDTH-1:0] word;
    logic [TDC_DATA_WIDTH-1:0] trailer_word;
    logic                      header_err;
    logic                      trailer_err;

    // Round-robin: first candidate strictly after last_grant, wrapping around.
    always_comb begin
        int idx;
        candidates  = readable & ~tdc_fifo_empty_array;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 1; k <= TDC_COUNT; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= TDC_COUNT) begin
                idx = idx - TDC_COUNT;
            end
            if (!grant_valid && candidates[idx[GW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = idx[GW-1:0];
            end
        end
    end

    assign grant_onehot = grant_valid ? (TDC_COUNT'(1) << grant_idx) : '0;
    assign grant_word   = tdc_fifo_data_array[grant_idx*TDC_DATA_WIDTH +: TDC_DATA_WIDTH];
    assign is_hdr       = (grant_word[31:24] == 8'hF8);
    assign is_trl       = (grant_word[31:24] == 8'hF0);
    assign is_hit       = !is_hdr && !is_trl;
    assign hit_fwd      = (max_hits == 10'd0) || (hit_count < max_hits);
    assign pop          = (state == SEND_DATA) && grant_valid && !readout_fifo_full;
    assign timeout_hit  = (state == SEND_DATA) && (timeout_cycles != '0) &&
                          (timer == timeout_cycles - TIMEOUT_WIDTH'(1)) && (readable != '0);

    assign header_err   = (header_found != event_mask);
    assign trailer_err  = (trailer_found != event_mask);
    assign trailer_word = {4'b1100, header_count, trailer_count, trig_reg[28:17],
                           header_err, trailer_err, timeout_flag, trunc_flag, hit_count};

    // Output handshake: a word is written into the readout FIFO on every cycle
    // event_data_ready is 1; readout_fifo_full=1 blocks both writes and TDC pops.
    always_comb begin
        word_valid = 1'b0;
        word       = '0;
        case (state)
            SEND_HEAD: begin
                word_valid = 1'b1;
                word       = {4'b1010, 7'b0, trig_reg};
            end
            SEND_DATA: begin
                word_valid = grant_valid && (!is_hit || hit_fwd);
                word       = grant_word;
            end
            SEND_TRAIL: begin
                word_valid = 1'b1;
                word       = trailer_word;
            end
            default: begin
                word_valid = 1'b0;
                word       = '0;
            end
        endcase
    end

    assign event_data_ready    = word_valid && !readout_fifo_full && !rst;
    assign event_data          = event_data_ready ? word : '0;
    assign tdc_fifo_read_array = grant_onehot &
                                 {TDC_COUNT{(state == SEND_DATA) && !readout_fifo_full}};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (enable && !trigger_fifo_empty) begin
                    state_nx = LOAD_TRIG;
                end
            end
            LOAD_TRIG: state_nx = SEND_HEAD;
            SEND_HEAD: begin
                if (!readout_fifo_full) begin
                    state_nx = SEND_DATA;
                end
            end
            SEND_DATA: begin
                if ((readable == '0) || timeout_hit) begin
                    state_nx = SEND_TRAIL;
                end
            end
            SEND_TRAIL: begin
                if (!readout_fifo_full) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            trigger_fifo_read <= 1'b0;
            building_busy     <= 1'b0;
        end else begin
            state             <= state_nx;
            trigger_fifo_read <= (state == IDLE) && (state_nx == LOAD_TRIG);
            building_busy     <= (state_nx != IDLE);
        end
    end

    // Per-event bookkeeping; all of it is cleared when the trigger is loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_reg      <= '0;
            event_mask    <= '0;
            readable      <= '0;
            header_found  <= '0;
            trailer_found <= '0;
            header_count  <= '0;
            trailer_count <= '0;
            hit_count     <= '0;
            timer         <= '0;
            timeout_flag  <= 1'b0;
            trunc_flag    <= 1'b0;
            last_grant    <= GW'(TDC_COUNT - 1);
        end else begin
            if (state == LOAD_TRIG) begin
                trig_reg      <= trigger_fifo_data;
                event_mask    <= locked_array & tdc_enable_mask;
                readable      <= locked_array & tdc_enable_mask;
                header_found  <= '0;
                trailer_found <= '0;
                header_count  <= '0;
                trailer_count <= '0;
                hit_count     <= '0;
                timer         <= '0;
                timeout_flag  <= 1'b0;
                trunc_flag    <= 1'b0;
            end
            if (state == SEND_DATA) begin
                timer <= timer + TIMEOUT_WIDTH'(1);
            end
            if (pop) begin
                last_grant <= grant_idx;
                if (is_hdr) begin
                    header_found[grant_idx] <= 1'b1;
                    if (header_count != 5'd31) begin
                        header_count <= header_count + 5'd1;
                    end
                end
                if (is_trl) begin
                    trailer_found[grant_idx] <= 1'b1;
                    readable[grant_idx]      <= 1'b0;
                    if (trailer_count != 5'd31) begin
                        trailer_count <= trailer_count + 5'd1;
                    end
                end
                if (is_hit) begin
                    if (hit_count != 10'd1023) begin
                        hit_count <= hit_count + 10'd1;
                    end
                    if (!hit_fwd) begin
                        trunc_flag <= 1'b1;
                    end
                end
            end
            // Abandon TDCs that never delivered a trailer; their leftovers stay queued.
            if (timeout_hit) begin
                timeout_flag <= 1'b1;
                readable     <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_count   <= '0;
            timeout_count <= '0;
        end else if ((state == SEND_TRAIL) && !readout_fifo_full) begin
            event_count <= event_count + 16'd1;
            if (timeout_flag && (timeout_count != 16'hFFFF)) begin
                timeout_count <= timeout_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_event_builder_rr_timeout.sv
// Directed bench for event_builder_rr_timeout: FIFO models feed the DUT, expected
// words are queued per scenario and a negedge monitor checks every written word.
module tb_event_builder_rr_timeout;

    localparam int N = 10;
    localparam int W = 40;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [N-1:0]   tdc_enable_mask;
    logic [15:0]    timeout_cycles;
    logic [9:0]     max_hits;
    logic           trigger_fifo_empty;
    logic [28:0]    trigger_fifo_data;
    logic           trigger_fifo_read;
    logic [N-1:0]   locked_array;
    logic [N-1:0]   tdc_fifo_empty_array;
    logic [N*W-1:0] tdc_fifo_data_array;
    logic [N-1:0]   tdc_fifo_read_array;
    logic           readout_fifo_full;
    logic [W-1:0]   event_data;
    logic           event_data_ready;
    logic           building_busy;
    logic [15:0]    event_count;
    logic [15:0]    timeout_count;

    logic [W-1:0] tdc_q [N][$];
    logic [28:0]  trig_q[$];
    logic [W-1:0] exp_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int words_seen = 0;
    int hdr_cyc = 0;
    int trl_cyc = 0;
    int last_gap = 0;

    event_builder_rr_timeout #(
        .TDC_COUNT(N), .TDC_DATA_WIDTH(W), .TIMEOUT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .tdc_enable_mask(tdc_enable_mask),
        .timeout_cycles(timeout_cycles), .max_hits(max_hits),
        .trigger_fifo_empty(trigger_fifo_empty), .trigger_fifo_data(trigger_fifo_data),
        .trigger_fifo_read(trigger_fifo_read), .locked_array(locked_array),
        .tdc_fifo_empty_array(tdc_fifo_empty_array), .tdc_fifo_data_array(tdc_fifo_data_array),
        .tdc_fifo_read_array(tdc_fifo_read_array), .readout_fifo_full(readout_fifo_full),
        .event_data(event_data), .event_data_ready(event_data_ready),
        .building_busy(building_busy), .event_count(event_count), .timeout_count(timeout_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            tdc_fifo_empty_array[i] = (tdc_q[i].size() == 0);
            tdc_fifo_data_array[i*W +: W] = (tdc_q[i].size() != 0) ? tdc_q[i][0] : '0;
        end
        trigger_fifo_empty = (trig_q.size() == 0);
        trigger_fifo_data  = (trig_q.size() != 0) ? trig_q[0] : '0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [W-1:0] tw(input int id, input logic [7:0] cls, input int n);
        return {8'(id), cls, 24'(n)};
    endfunction
    function automatic logic [W-1:0] hdr(input int id);
        return tw(id, 8'hF8, 16'hA000 + id);
    endfunction
    function automatic logic [W-1:0] trl(input int id);
        return tw(id, 8'hF0, 16'hB000 + id);
    endfunction
    function automatic logic [W-1:0] hit(input int id, input int n);
        return tw(id, 8'h11, n);
    endfunction
    function automatic logic [W-1:0] head_word(input logic [28:0] t);
        return {4'b1010, 7'b0, t};
    endfunction
    function automatic logic [W-1:0] trail_word(input int hc, input int tc, input logic [28:0] t,
                                                input logic herr, input logic terr,
                                                input logic to, input logic tr, input int hits);
        return {4'b1100, 5'(hc), 5'(tc), t[28:17], herr, terr, to, tr, 10'(hits)};
    endfunction

    task automatic push_trig(input logic [28:0] t);
        trig_q.push_back(t);
        refresh();
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || building_busy) && n < 600) begin
            step(1);
            n++;
        end
        if (n >= 600) begin
            checks++;
            failures++;
            $display("FAIL %s_done got=pending(%0d words) exp=0", name, exp_q.size());
            exp_q.delete();
        end
        step(2);
    endtask

    // ---------------- FIFO models ----------------
    always @(posedge clk) begin : fifo_model
        logic [N-1:0] rd;
        logic         trd;
        rd  = tdc_fifo_read_array;
        trd = trigger_fifo_read;
        #1;
        for (int i = 0; i < N; i++) begin
            if (rd[i]) begin
                check("pop_nonempty", 64'(tdc_q[i].size() != 0), 64'd1);
                if (tdc_q[i].size() != 0) void'(tdc_q[i].pop_front());
            end
        end
        if (trd && trig_q.size() != 0) void'(trig_q.pop_front());
        refresh();
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : monitor
        logic [W-1:0] e;
        if (event_data_ready) begin
            words_seen++;
            if (event_data[39:36] == 4'hA) begin
                last_gap = cyc - trl_cyc;
                hdr_cyc  = cyc;
            end
            if (event_data[39:36] == 4'hC) trl_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word got=%h exp=none", event_data);
            end else begin
                e = exp_q.pop_front();
                check("event_word", 64'(event_data), 64'(e));
            end
        end
        if (readout_fifo_full && !rst) begin
            check("stall_no_pop", 64'(tdc_fifo_read_array), 64'd0);
            check("stall_no_write", 64'(event_data_ready), 64'd0);
            check("stall_data_zero", 64'(event_data), 64'd0);
        end
    end

    // ---------------- directed scenarios ----------------
    initial begin
        logic [28:0] t;
        int base;
        int n;
        rst = 1'b1;
        enable = 1'b1;
        tdc_enable_mask = '0;
        timeout_cycles = '0;
        max_hits = '0;
        locked_array = 10'h3FF;
        readout_fifo_full = 1'b0;
        refresh();
        step(3);
        check("rst_busy", 64'(building_busy), 64'd0);
        check("rst_trig_read", 64'(trigger_fifo_read), 64'd0);
        check("rst_event_count", 64'(event_count), 64'd0);
        check("rst_timeout_count", 64'(timeout_count), 64'd0);
        check("rst_ready", 64'(event_data_ready), 64'd0);
        check("rst_tdc_read", 64'(tdc_fifo_read_array), 64'd0);
        rst = 1'b0;
        step(2);

        // Two TDCs alternating; last_grant starts at 9 so TDC0 goes first.
        tdc_enable_mask = 10'h003;
        t = 29'h1ABCDEF;
        tdc_q[0] = '{hdr(0), hit(0, 1), hit(0, 2), trl(0)};
        tdc_q[1] = '{hdr(1), hit(1, 1), trl(1)};
        exp_q = '{head_word(t), hdr(0), hdr(1), hit(0, 1), hit(1, 1), hit(0, 2), trl(1), trl(0),
                  trail_word(2, 2, t, 0, 0, 0, 0, 3)};
        push_trig(t);
        wait_done("alternate");
        check("ev_count_1", 64'(event_count), 64'd1);

        // TDC1 never sends a trailer; last_grant=0 so TDC1 is granted first.
        timeout_cycles = 16'd20;
        t = 29'h15A5A5A5;
        tdc_q[0] = '{hdr(0), trl(0)};
        tdc_q[1] = '{hdr(1), hit(1, 7)};
        exp_q = '{head_word(t), hdr(1), hdr(0), hit(1, 7), trl(0),
                  trail_word(2, 1, t, 0, 1, 1, 0, 1)};
        push_trig(t);
        wait_done("timeout");
        check("timeout_latency", 64'(trl_cyc - hdr_cyc), 64'd21);
        check("timeout_count_1", 64'(timeout_count), 64'd1);
        check("ev_count_2", 64'(event_count), 64'd2);
        timeout_cycles = '0;

        // Hit limit: five hits popped, two forwarded.
        max_hits = 10'd2;
        tdc_enable_mask = 10'h001;
        t = 29'h01234567;
        tdc_q[0] = '{hdr(0), hit(0, 1), hit(0, 2), hit(0, 3), hit(0, 4), hit(0, 5), trl(0)};
        exp_q = '{head_word(t), hdr(0), hit(0, 1), hit(0, 2), trl(0),
                  trail_word(1, 1, t, 0, 0, 0, 1, 5)};
        push_trig(t);
        wait_done("trunc");
        check("trunc_all_popped", 64'(tdc_q[0].size()), 64'd0);
        check("ev_count_3", 64'(event_count), 64'd3);
        max_hits = '0;

        // Readout full for 10 cycles mid-event.
        tdc_enable_mask = 10'h003;
        t = 29'h1FFFFFFF;
        tdc_q[0] = '{hdr(0), hit(0, 1), hit(0, 2), trl(0)};
        tdc_q[1] = '{hdr(1), hit(1, 1), trl(1)};
        exp_q = '{head_word(t), hdr(1), hdr(0), hit(1, 1), hit(0, 1), trl(1), hit(0, 2), trl(0),
                  trail_word(2, 2, t, 0, 0, 0, 0, 3)};
        base = words_seen;
        push_trig(t);
        n = 0;
        while (words_seen < base + 3 && n < 100) begin
            step(1);
            n++;
        end
        check("stall_reached", 64'(words_seen >= base + 3), 64'd1);
        readout_fifo_full = 1'b1;
        step(10);
        readout_fifo_full = 1'b0;
        wait_done("stall");
        check("ev_count_4", 64'(event_count), 64'd4);

        // All TDCs locked but only TDC0 enabled.
        tdc_enable_mask = 10'h001;
        t = 29'h00000001 << 17;
        tdc_q[0] = '{hdr(0), hit(0, 9), trl(0)};
        tdc_q[1] = '{hdr(1), hit(1, 9), trl(1)};
        tdc_q[2] = '{hdr(2)};
        exp_q = '{head_word(t), hdr(0), hit(0, 9), trl(0), trail_word(1, 1, t, 0, 0, 0, 0, 1)};
        push_trig(t);
        wait_done("masked");
        check("masked_tdc1_untouched", 64'(tdc_q[1].size()), 64'd3);
        check("masked_tdc2_untouched", 64'(tdc_q[2].size()), 64'd1);
        tdc_q[1].delete();
        tdc_q[2].delete();
        refresh();

        // Empty event mask, two triggers back to back.
        tdc_enable_mask = 10'h000;
        exp_q = '{head_word(29'h0AAAAAAA), trail_word(0, 0, 29'h0AAAAAAA, 0, 0, 0, 0, 0),
                  head_word(29'h15555555), trail_word(0, 0, 29'h15555555, 0, 0, 0, 0, 0)};
        trig_q.push_back(29'h0AAAAAAA);
        push_trig(29'h15555555);
        wait_done("empty_mask");
        check("empty_event_len", 64'(trl_cyc - hdr_cyc), 64'd2);
        check("back_to_back_gap", 64'(last_gap), 64'd3);
        check("ev_count_7", 64'(event_count), 64'd7);

        // Reset while parked in SEND_DATA waiting for a trailer.
        tdc_enable_mask = 10'h001;
        t = 29'h0BADBEEF;
        tdc_q[0] = '{hdr(0), hit(0, 3)};
        exp_q = '{head_word(t), hdr(0), hit(0, 3)};
        push_trig(t);
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step(1);
            n++;
        end
        step(3);
        check("parked_busy", 64'(building_busy), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_ready", 64'(event_data_ready), 64'd0);
        check("midrst_data", 64'(event_data), 64'd0);
        check("midrst_busy", 64'(building_busy), 64'd0);
        check("midrst_tdc_read", 64'(tdc_fifo_read_array), 64'd0);
        check("midrst_event_count", 64'(event_count), 64'd0);
        check("midrst_timeout_count", 64'(timeout_count), 64'd0);
        step(2);
        rst = 1'b0;
        step(1);

        // Clean event after reset; last_grant back at 9.
        tdc_enable_mask = 10'h003;
        t = 29'h12345678;
        tdc_q[0] = '{hdr(0), trl(0)};
        tdc_q[1] = '{hdr(1), trl(1)};
        exp_q = '{head_word(t), hdr(0), hdr(1), trl(0), trl(1), trail_word(2, 2, t, 0, 0, 0, 0, 0)};
        push_trig(t);
        wait_done("post_reset");
        check("post_rst_event_count", 64'(event_count), 64'd1);
        check("post_rst_timeout_count", 64'(timeout_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
